// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole sequencer picking boxes, timing moles, scoring hits and misses
module mole_game_ctrl #(
    parameter int         NUM_BOXES = 10,
    parameter int         TICK_DIV  = 100000,
    parameter int         UP_TICKS  = 1000,
    parameter int         GAP_TICKS = 300,
    parameter int         MAX_MISS  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit_valid,
    input  logic [3:0] hit_idx,
    output logic [3:0] selected_box,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic       game_over,
    output logic       busy
);
    localparam logic [1:0] IDLE = 2'd0, GAP = 2'd1, UP = 2'd2, OVER = 2'd3;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2((UP_TICKS > GAP_TICKS ? UP_TICKS : GAP_TICKS) + 1);
    logic [1:0] state, nxt;
    logic [PW-1:0] pre;
    logic [TW-1:0] cnt;
    logic [7:0] lfsr;
    logic [3:0] prev_box, c0, pick;
    logic tick, expire, hit, last_miss;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign expire = tick && cnt == (state == UP ? TW'(UP_TICKS - 1) : TW'(GAP_TICKS - 1));
    // selected_box holds the live mole while in UP, so a hit is a match against it
    assign hit = state == UP && hit_valid && hit_idx == selected_box;
    assign last_miss = 2'(misses + 2'd1) == 2'(MAX_MISS);
    assign c0 = lfsr[3:0] >= 4'(NUM_BOXES) ? lfsr[3:0] - 4'(NUM_BOXES) : lfsr[3:0];
    assign pick = c0 == prev_box ? (c0 == 4'(NUM_BOXES - 1) ? 4'd0 : c0 + 4'd1) : c0;
    // next-state decision
    always_comb begin
        nxt = state;
        case (state)
            IDLE, OVER: nxt = start ? GAP : state;
            GAP:        nxt = expire ? UP : GAP;
            default:    nxt = hit ? GAP : expire ? (last_miss ? OVER : GAP) : UP;
        endcase
    end
    // prescaler and tick counter, both restarted on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (nxt != state) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            cnt <= cnt + TW'(tick);
        end
    end
    // free-running LFSR, taps x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    // state, registered outputs, scoring and box memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            selected_box <= 4'hF;
            score        <= '0;
            misses       <= '0;
            game_over    <= 1'b0;
            busy         <= 1'b0;
            prev_box     <= 4'hF;
        end else begin
            state        <= nxt;
            selected_box <= nxt == UP ? (state == UP ? selected_box : pick) : 4'hF;
            busy         <= nxt == GAP || nxt == UP;
            game_over    <= nxt == OVER;
            if ((state == IDLE || state == OVER) && start) begin
                score  <= '0;
                misses <= '0;
            end
            if (hit && score != 8'hFF) score <= score + 8'd1;
            if (state == UP && expire && !hit) misses <= misses + 2'd1;
            if (state == GAP && expire) prev_box <= pick;
        end
    end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: randomized game stimulus checked against a cycle-count reference model
module tb_mole_game_ctrl;
    localparam int NB = 10, TD = 4, UT = 5, GT = 2, MM = 3;
    localparam logic [7:0] SEED = 8'hA5;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hit_valid = 1'b0;
    logic [3:0] hit_idx = 4'd0, selected_box;
    logic [7:0] score;
    logic [1:0] misses;
    logic game_over, busy;
    always #5 clk = ~clk;
    mole_game_ctrl #(.NUM_BOXES(NB), .TICK_DIV(TD), .UP_TICKS(UT), .GAP_TICKS(GT),
                     .MAX_MISS(MM), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .selected_box(selected_box), .score(score), .misses(misses),
        .game_over(game_over), .busy(busy));
    typedef enum {M_IDLE, M_GAP, M_UP, M_OVER} mst_t;
    mst_t m_st;
    int m_rem, m_box, m_prev, m_score, m_miss;
    logic [7:0] m_lfsr;
    int n_chk = 0, n_pass = 0, picks = 0, last_pick = 15, prev_sel = 15;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    function automatic void m_reset();
        m_st = M_IDLE; m_rem = 0; m_box = 15; m_prev = 15;
        m_score = 0; m_miss = 0; m_lfsr = SEED;
        last_pick = 15; prev_sel = 15;
    endfunction
    // each phase lasts its tick count times the prescale, counted in plain cycles
    function automatic void m_enter(input mst_t s);
        m_st = s;
        m_rem = (s == M_UP ? UT : GT) * TD;
    endfunction
    function automatic void m_step(input logic st, input logic hv, input logic [3:0] hi);
        int c;
        case (m_st)
            M_IDLE, M_OVER: if (st) begin m_score = 0; m_miss = 0; m_enter(M_GAP); end
            M_GAP: if (m_rem == 1) begin
                c = int'(m_lfsr[3:0]);
                if (c >= NB) c -= NB;
                if (c == m_prev) c = (c + 1) % NB;
                m_prev = c; m_box = c;
                m_enter(M_UP);
            end else m_rem--;
            M_UP: if (hv && int'(hi) == m_box) begin
                m_score = m_score == 255 ? 255 : m_score + 1;
                m_enter(M_GAP);
            end else if (m_rem == 1) begin
                m_miss++;
                m_enter(m_miss == MM ? M_OVER : M_GAP);
            end else m_rem--;
            default: ;
        endcase
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endfunction
    task automatic check_outs();
        chk("selected_box", int'(selected_box), m_st == M_UP ? m_box : 15);
        chk("score", int'(score), m_score);
        chk("misses", int'(misses), m_miss);
        chk("game_over", int'(game_over), int'(m_st == M_OVER));
        chk("busy", int'(busy), int'(m_st == M_GAP || m_st == M_UP));
        if (selected_box != 4'hF && prev_sel == 15) begin
            picks++;
            chk("pick_in_range", int'(selected_box < 4'(NB)), 1);
            chk("pick_not_repeat", int'(int'(selected_box) != last_pick), 1);
            last_pick = int'(selected_box);
        end
        prev_sel = int'(selected_box);
    endtask
    task automatic cyc(input logic st, input logic hv, input logic [3:0] hi);
        check_outs();
        start = st; hit_valid = hv; hit_idx = hi;
        @(posedge clk);
        m_step(st, hv, hi);
        @(negedge clk);
    endtask
    task automatic run(input int n, input int ps, input int pok, input int pbad, input bit edge_hit);
        logic st, hv;
        logic [3:0] hi;
        int r;
        for (int i = 0; i < n; i++) begin
            st = ($urandom % 100) < 32'(ps);
            r = int'($urandom % 100);
            hv = 1'b0;
            hi = 4'($urandom % 16);
            if (m_st == M_UP && edge_hit && m_rem == 1) begin hv = 1'b1; hi = 4'(m_box); end
            else if (m_st == M_UP && r < pok) begin hv = 1'b1; hi = 4'(m_box); end
            else if (r < pok + pbad) hv = 1'b1;
            cyc(st, hv, hi);
        end
    endtask
    initial begin
        m_reset();
        @(negedge clk); @(negedge clk);
        check_outs();
        rst = 1'b0;
        repeat (10) cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 4'd0);
        repeat (3 * (UT + GT) * TD + 10) cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 100 && m_st != M_UP; k++) cyc(1'b0, 1'b0, 4'd0);
        chk("reached_up", int'(m_st == M_UP), 1);
        cyc(1'b0, 1'b1, 4'((m_box + 1) % NB));
        cyc(1'b0, 1'b1, 4'(m_box));
        run(800, 3, 6, 10, 1'b0);
        run(800, 5, 0, 10, 1'b1);
        for (int k = 0; k < 6000 && picks < 60; k++) run(1, 5, 5, 5, k[0]);
        chk("enough_picks", int'(picks >= 50), 1);
        for (int k = 0; k < 300 && !(m_st == M_UP && m_score > 0); k++) run(1, 50, 8, 0, 1'b0);
        #1 rst = 1'b1;
        #1 m_reset();
        check_outs();
        @(negedge clk);
        check_outs();
        rst = 1'b0;
        run(300, 5, 6, 10, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
